// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller and datapath.
// Holds opcode constants, FSM state encodings, the datapath select encodings
// (alu_src_b, alu_op, pc_src) and the packed control word from the decoder.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_outdec.sv
// State -> control word decoder (purely combinational, Moore outputs).
// Only the IF load enables depend on mem_ready. rst forces the whole control
// word to zero so requests drop the moment reset rises.
// Optional MC_CTRL_ILLEGAL_TRAP_EN adds illegal_instr, high in TRAP.
// Ports: st (current state), mem_ready, rst, cw (control word),
//        illegal_instr (only with MC_CTRL_ILLEGAL_TRAP_EN).
module mc_ctrl_fsm_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t st,
  input  logic   mem_ready,
  input  logic   rst,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic   illegal_instr,
`endif
  output ctrl_t  cw
);

  always_comb begin
    cw = '0;
    case (st)
      S_IF: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_4;
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      S_ID:     cw.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      S_MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      S_EXE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_src        = PCSRC_ALUOUT;
        cw.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        cw.pc_src   = PCSRC_JUMP;
        cw.pc_write = 1'b1;
      end
      S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: cw.reg_write = 1'b1;
      default:  cw = '0;
    endcase
    if (rst) cw = '0;
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_instr = (st == S_TRAP) && !rst;
`endif

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM: state register + next-state logic.
// Output decode lives in mc_ctrl_fsm_outdec.
// Ports: clk, rst (async, active-high), opcode (IR[31:26]), zero (ALU flag),
//        mem_ready; control outputs pc_en, ir_write, reg_write, mem_read,
//        mem_write, iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
//        pc_src; state (debug); illegal_instr with MC_CTRL_ILLEGAL_TRAP_EN.
// MC_CTRL_ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP until reset.
// Without it an unknown opcode retires as a NOP (PC was advanced in IF).
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_en,
  output logic           ir_write,
  output logic           reg_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           iord,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_src,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic           illegal_instr,
`endif
  output logic [STW-1:0] state
);

  state_t     cur, nxt;
  ctrl_t      cw;
  logic [5:0] op6;

  assign op6 = 6'(opcode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_IF;
    else     cur <= nxt;
  end

  // opcode is only looked at in ID and MEMADR; IR is stable there.
  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF: nxt = mem_ready ? S_ID : S_IF;
      S_ID: begin
        case (op6)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXE;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDIEX;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:      nxt = S_TRAP;
`else
          default:      nxt = S_IF;
`endif
        endcase
      end
      S_MEMADR: nxt = (op6 == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt = S_IF;
      S_MEMWR:  nxt = mem_ready ? S_IF : S_MEMWR;
      S_EXE:    nxt = S_ALUWB;
      S_ALUWB:  nxt = S_IF;
      S_BRANCH: nxt = S_IF;
      S_JUMP:   nxt = S_IF;
      S_ADDIEX: nxt = S_ADDIWB;
      S_ADDIWB: nxt = S_IF;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   nxt = S_TRAP;
`endif
      default:  nxt = S_IF;
    endcase
  end

  mc_ctrl_fsm_outdec u_outdec (
    .st            (cur),
    .mem_ready     (mem_ready),
    .rst           (rst),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    .illegal_instr (illegal_instr),
`endif
    .cw            (cw)
  );

  assign pc_en      = cw.pc_write | (cw.pc_write_cond & zero);
  assign ir_write   = cw.ir_write;
  assign reg_write  = cw.reg_write;
  assign mem_read   = cw.mem_read;
  assign mem_write  = cw.mem_write;
  assign iord       = cw.iord;
  assign reg_dst    = cw.reg_dst;
  assign mem_to_reg = cw.mem_to_reg;
  assign alu_src_a  = cw.alu_src_a;
  assign alu_src_b  = cw.alu_src_b;
  assign alu_op     = cw.alu_op;
  assign pc_src     = cw.pc_src;
  assign state      = STW'(cur);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero, mem_ready;
  logic       pc_en, ir_write, reg_write, mem_read, mem_write;
  logic       iord, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

  mc_ctrl_fsm #(.OPW(6), .STW(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    .illegal_instr(illegal_instr),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  // One cycle: inputs change at negedge, outputs sampled 1ns later.
  task automatic cyc(input logic mr, input logic z);
    @(negedge clk);
    mem_ready = mr;
    zero      = z;
    #1;
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == R || op == LW || op == SW || op == BEQ || op == J || op == ADDI;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = LW;
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++;
    if ({pc_en, ir_write, reg_write, mem_read, mem_write} !== 5'b0) begin
      errors++; $display("FAIL reset_enables got %b want 00000",
                         {pc_en, ir_write, reg_write, mem_read, mem_write});
    end
    checks++;
    if ({iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src} !== 10'b0) begin
      errors++; $display("FAIL reset_selects got %b want 0",
                         {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src});
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_lw;
    int exp_s[5] = '{0, 1, 2, 3, 4};
    opcode = LW;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      checks++;
      if (state !== 4'(exp_s[i])) begin
        errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, exp_s[i]);
      end
      checks++;
      if (reg_write !== (i == 4) || mem_to_reg !== (i == 4) || pc_en !== (i == 0)) begin
        errors++; $display("FAIL lw_ctrl[%0d] got rw=%b m2r=%b pce=%b", i, reg_write,
                           mem_to_reg, pc_en);
      end
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL lw_end got %0d want 0", state); end
  endtask

  task automatic test_beq;
    for (int zv = 0; zv < 2; zv++) begin
      opcode = BEQ;
      cyc(1'b1, 1'(zv));
      cyc(1'b1, 1'(zv));
      cyc(1'b1, 1'(zv));
      checks++;
      if (state !== 4'd8 || pc_en !== 1'(zv) || pc_src !== 2'b01) begin
        errors++; $display("FAIL beq_z%0d got st=%0d pce=%b pcsrc=%b want 8 %0d 01",
                           zv, state, pc_en, pc_src, zv);
      end
      cyc(1'b0, 1'b0);
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL beq_end got %0d want 0", state); end
    end
  endtask

  task automatic test_if_stall;
    opcode = ADDI;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      checks++;
      if (state !== 4'd0 || ir_write !== 1'b0 || pc_en !== 1'b0) begin
        errors++; $display("FAIL if_stall[%0d] got st=%0d irw=%b pce=%b want 0 0 0",
                           i, state, ir_write, pc_en);
      end
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (state !== 4'd0 || ir_write !== 1'b1 || pc_en !== 1'b1) begin
      errors++; $display("FAIL if_release got st=%0d irw=%b pce=%b want 0 1 1",
                         state, ir_write, pc_en);
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL if_to_id got %0d want 1", state); end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    checks++;
    if (state !== 4'd11 || reg_write !== 1'b1) begin
      errors++; $display("FAIL addi_wb got st=%0d rw=%b want 11 1", state, reg_write);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_sw_reset;
    opcode = SW;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      errors++; $display("FAIL sw_memwr got st=%0d mw=%b want 5 1", state, mem_write);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || state !== 4'd0) begin
      errors++; $display("FAIL sw_async_rst got mw=%b st=%0d want 0 0", mem_write, state);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_write !== 1'b0 || state !== 4'd0) begin
      errors++; $display("FAIL sw_rst_hold got mw=%b st=%0d want 0 0", mem_write, state);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    int exp_s[7] = '{0, 1, 6, 7, 0, 1, 9};
    for (int i = 0; i < 7; i++) begin
      opcode = (i < 4) ? R : J;
      cyc(1'b1, 1'b0);
      checks++;
      if (state !== 4'(exp_s[i])) begin
        errors++; $display("FAIL b2b_state[%0d] got %0d want %0d", i, state, exp_s[i]);
      end
    end
    checks++;
    if (pc_src !== 2'b10 || pc_en !== 1'b1) begin
      errors++; $display("FAIL jump_ctrl got pcsrc=%b pce=%b want 10 1", pc_src, pc_en);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL b2b_end got %0d want 0", state); end
  endtask

  task automatic test_illegal;
    opcode = 6'b111111;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL ill_id got %0d want 1", state); end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (state !== 4'd12 || illegal_instr !== 1'b1 || pc_en !== 1'b0 || mem_read !== 1'b0) begin
        errors++; $display("FAIL trap[%0d] got st=%0d ill=%b pce=%b mr=%b", i, state,
                           illegal_instr, pc_en, mem_read);
      end
    end
    test_reset;
    cyc(1'b0, 1'b0);
    checks++;
    if (state !== 4'd0 || illegal_instr !== 1'b0) begin
      errors++; $display("FAIL trap_clear got st=%0d ill=%b want 0 0", state, illegal_instr);
    end
`else
    cyc(1'b0, 1'b0);
    checks++;
    if (state !== 4'd0 || reg_write !== 1'b0) begin
      errors++; $display("FAIL ill_nop got st=%0d rw=%b want 0 0", state, reg_write);
    end
`endif
  endtask

  // Instruction-level reference: each instruction is a list of phase states
  // from the ISA's step table; memory phases get random extra stall cycles.
  // Pulse counts per instruction are checked against what the ISA demands.
  task automatic test_random;
    logic [5:0] ops[6] = '{R, LW, SW, BEQ, J, ADDI};
    for (int n = 0; n < 80; n++) begin
      int         q_st[$];
      bit         q_mr[$];
      logic [5:0] op;
      logic       z;
      int         k, irw, pce, rw, wr, rd, m2r, rdst;
      int         e_pce;
      q_st.delete(); q_mr.delete();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      op = ops[$urandom_range(0, 5)];
`else
      if ($urandom_range(0, 6) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else op = ops[$urandom_range(0, 5)];
`endif
      z = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 2);
      repeat (k) begin q_st.push_back(0); q_mr.push_back(1'b0); end
      q_st.push_back(0); q_mr.push_back(1'b1);
      q_st.push_back(1); q_mr.push_back(1'($urandom_range(0, 1)));
      if (op == LW || op == SW) begin
        q_st.push_back(2); q_mr.push_back(1'($urandom_range(0, 1)));
        k = $urandom_range(0, 2);
        repeat (k) begin q_st.push_back(op == LW ? 3 : 5); q_mr.push_back(1'b0); end
        q_st.push_back(op == LW ? 3 : 5); q_mr.push_back(1'b1);
        if (op == LW) begin q_st.push_back(4); q_mr.push_back(1'($urandom_range(0, 1))); end
      end else if (op == R) begin
        q_st.push_back(6); q_mr.push_back(1'($urandom_range(0, 1)));
        q_st.push_back(7); q_mr.push_back(1'($urandom_range(0, 1)));
      end else if (op == BEQ) begin
        q_st.push_back(8); q_mr.push_back(1'($urandom_range(0, 1)));
      end else if (op == J) begin
        q_st.push_back(9); q_mr.push_back(1'($urandom_range(0, 1)));
      end else if (op == ADDI) begin
        q_st.push_back(10); q_mr.push_back(1'($urandom_range(0, 1)));
        q_st.push_back(11); q_mr.push_back(1'($urandom_range(0, 1)));
      end
      opcode = op;
      irw = 0; pce = 0; rw = 0; wr = 0; rd = 0; m2r = 0; rdst = 0;
      for (int i = 0; i < q_st.size(); i++) begin
        cyc(q_mr[i], z);
        checks++;
        if (state !== 4'(q_st[i])) begin
          errors++; $display("FAIL rnd%0d_state[%0d] op=%b got %0d want %0d", n, i, op,
                             state, q_st[i]);
        end
        irw  += int'(ir_write);
        pce  += int'(pc_en);
        rw   += int'(reg_write);
        wr   += int'(mem_write & mem_ready);
        rd   += int'(mem_read & mem_ready);
        m2r  += int'(reg_write & mem_to_reg);
        rdst += int'(reg_write & reg_dst);
      end
      cyc(1'b0, 1'b0);
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL rnd%0d_end got %0d want 0", n, state); end
      e_pce = 1 + int'(op == J) + int'(op == BEQ && z);
      checks++;
      if (irw != 1 || pce != e_pce) begin
        errors++; $display("FAIL rnd%0d_fetch op=%b got irw=%0d pce=%0d want 1 %0d", n, op,
                           irw, pce, e_pce);
      end
      checks++;
      if (rw != int'(op == LW || op == R || op == ADDI) || m2r != int'(op == LW) ||
          rdst != int'(op == R)) begin
        errors++; $display("FAIL rnd%0d_wb op=%b got rw=%0d m2r=%0d rdst=%0d", n, op, rw,
                           m2r, rdst);
      end
      checks++;
      if (wr != int'(op == SW) || rd != 1 + int'(op == LW)) begin
        errors++; $display("FAIL rnd%0d_mem op=%b got wr=%0d rd=%0d", n, op, wr, rd);
      end
    end
  endtask

  initial begin
    rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    test_reset;
    test_lw;
    test_beq;
    test_if_stall;
    test_sw_reset;
    test_back_to_back;
    test_illegal;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Moore-style control FSM for the multi-cycle MIPS-subset datapath.
- Decodes opcode and sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select and every write enable.
- The datapath 2:1/4:1 selectors consume its select outputs; it is the producer side of that select interface.

Parameters:
OPW, 6, opcode width
STW, 4, state register width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  OPW  IR[31:26]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the access this cycle
pc_en  output  1  PC load = pc_write | (pc_write_cond & zero)
ir_write  output  1  IR load
reg_write  output  1  register file write
mem_read  output  1  memory read request
mem_write  output  1  memory write request
iord  output  1  0=PC, 1=ALUOut address
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=4, 10=sext imm, 11=sext imm<<2
alu_op  output  2  00 add, 01 sub, 10 funct-decoded
pc_src  output  2  00=ALU, 01=ALUOut, 10=jump target
state  output  STW  current state, for debug

Behaviour:
- Reset: asynchronous, active-high; state <= IF immediately. While rst=1, all enables and requests (pc_en, ir_write, reg_write, mem_read, mem_write) are forced to 0 and all selects to 0.
- Outputs decode combinationally from the state register. Exceptions: ir_write and pc_write in IF, and the exit of MEMRD/MEMWR, are gated by mem_ready.
- Opcodes:
  - R=000000
  - LW=100011
  - SW=101011
  - BEQ=000100
  - J=000010
  - ADDI=001000
- States (encoding) and asserted outputs. Unlisted outputs are 0.
  - IF(0): mem_read, alu_src_b=01; ir_write=pc_write=mem_ready. Stay in IF until mem_ready=1, then go to ID.
  - ID(1): alu_src_b=11 (branch target precompute). Next state by opcode:
    - LW/SW -> MEMADR
    - R -> EXE
    - BEQ -> BRANCH
    - J -> JUMP
    - ADDI -> ADDIEX
    - other -> see optional feature
  - MEMADR(2): alu_src_a=1, alu_src_b=10. LW -> MEMRD, SW -> MEMWR.
  - MEMRD(3): mem_read, iord. Wait on mem_ready, then -> MEMWB.
  - MEMWB(4): reg_write, mem_to_reg. -> IF.
  - MEMWR(5): mem_write, iord. Wait on mem_ready, then -> IF.
  - EXE(6): alu_src_a=1, alu_op=10. -> ALUWB.
  - ALUWB(7): reg_write, reg_dst. -> IF.
  - BRANCH(8): alu_src_a=1, alu_op=01, pc_src=01, pc_write_cond. -> IF.
  - JUMP(9): pc_src=10, pc_write. -> IF.
  - ADDIEX(10): alu_src_a=1, alu_src_b=10. -> ADDIWB.
  - ADDIWB(11): reg_write. -> IF.
  - TRAP(12): see optional feature.
- Cycle counts with mem_ready held at 1:
  - LW = 5
  - SW, R, ADDI = 4
  - BEQ, J = 3
- Each stall cycle (mem_ready=0) adds exactly one cycle. During a stall, outputs hold and no enable pulses.
- opcode is sampled only in ID and MEMADR; the IR is stable outside IF.
- Unused encodings 13-15 -> IF next cycle, all enables 0.
- Reset during MEMWR or MEMRD: the request drops in the same cycle; no write completes after rst rises.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in ID goes to TRAP. TRAP holds all enables at 0, drives an extra output illegal_instr=1, and stays there until reset.
- Undefined: an unknown opcode in ID goes to IF as a NOP, with PC already advanced. TRAP is unreachable and the illegal_instr port does not exist.

Decomposition:
- Shared package/header holds:
  - opcode constants
  - state encodings
  - alu_src_b, alu_op and pc_src select encodings
- The datapath mux instances use the same select constants.
- Natural sub-module: mc_ctrl_outdec (state -> control word decoder, purely combinational). The FSM top keeps only the state register and next-state logic.

Test Plan:
- rst pulse, then LW opcode 100011, mem_ready=1: states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4; pc_en=1 only in the first cycle.
- BEQ 000100 with zero=1: pc_en=1 in BRANCH with pc_src=01. Repeat with zero=0: pc_en=0 in BRANCH.
- IF with mem_ready=0 for 3 cycles, then 1: FSM stays in state 0 for 4 cycles; ir_write and pc_en pulse once, in the 4th cycle.
- SW 101011, assert rst asynchronously mid-MEMWR: mem_write falls with rst before the next edge; state=0 after rst.
- R then J back-to-back, mem_ready=1: total 7 cycles. JUMP asserts pc_src=10 and pc_en=1.
- Opcode 111111: with macro defined, state=12, illegal_instr=1 and persists until reset; without it, state returns to 0 after ID.
